// File: rtl/etapa_mem_wb.sv
// ---------------------------------------------------------------------------
// etapa_mem_wb -- MEM stage controller and MEM/WB pipeline register.
//
// Takes the EX/MEM buffer outputs, runs loads/stores against the data memory
// over a req/ack handshake, and fills the MEM/WB register for write-back.
// It also forwards the taken-branch redirect to the PC and stalls upstream
// stages while a memory access is outstanding.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   *_MEM inputs               control, address/ALU result, store data and
//                              destination register from EX/MEM
//   mem_req/we/addr/wdata      registered request to the data memory
//   mem_ack, mem_rdata         one-cycle completion pulse and read data
//   stall_MEM                  freeze upstream stages (combinational)
//   pc_src, pc_branch          PC redirect select/target (combinational)
//   *_WB outputs               MEM/WB pipeline register
//   error_MEM                  one-cycle pulse: misaligned access,
//                              read+write conflict, or memory timeout
// ---------------------------------------------------------------------------
module etapa_mem_wb #(
  parameter int unsigned TIMEOUT_CICLOS = 255,
  parameter int unsigned CONT_ANCHO     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_escribir_MEM,
  input  logic        mem_a_reg_MEM,
  input  logic        mem_escribir_MEM,
  input  logic        mem_leer_MEM,
  input  logic        branch_habilitado_MEM,
  input  logic [31:0] branch_target_MEM,
  input  logic [31:0] resultado_alu_MEM,
  input  logic [31:0] dr2_forward_MEM,
  input  logic [4:0]  registro_destino_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_MEM,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic        reg_escribir_WB,
  output logic        mem_a_reg_WB,
  output logic [31:0] dato_leido_WB,
  output logic [31:0] resultado_alu_WB,
  output logic [4:0]  registro_destino_WB,
  output logic        error_MEM
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ESPERA = 1'b1
  } estado_t;

  // The timeout fires in the ESPERA cycle whose increment would reach
  // TIMEOUT_CICLOS, so the access lasts exactly TIMEOUT_CICLOS ESPERA cycles.
  localparam logic [CONT_ANCHO-1:0] CONT_LIMITE = CONT_ANCHO'(TIMEOUT_CICLOS - 1);

  estado_t               estado_q;
  logic [CONT_ANCHO-1:0] cont_q;
  logic                  lat_reg_escribir_q;
  logic                  lat_mem_a_reg_q;
  logic [4:0]            lat_destino_q;

  logic                  hay_op_s;
  logic                  acceso_valido_s;
  logic                  timeout_s;

  // Word accesses only: both low address bits must be zero.
  function automatic logic es_alineado(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Request decode, timeout detection, stall and branch redirect.
  always_comb begin
    hay_op_s        = mem_leer_MEM | mem_escribir_MEM;
    acceso_valido_s = (mem_leer_MEM ^ mem_escribir_MEM) & es_alineado(resultado_alu_MEM);
    timeout_s       = (estado_q == ESPERA) && (cont_q == CONT_LIMITE);
    stall_MEM       = 1'b0;
    case (estado_q)
      IDLE: begin
        if (hay_op_s && acceso_valido_s) begin
          stall_MEM = 1'b1;
        end else begin
          stall_MEM = 1'b0;
        end
      end
      ESPERA: begin
        // Release upstream in the ack cycle and in the timeout cycle.
        stall_MEM = ~mem_ack & ~timeout_s;
      end
      default: begin
        stall_MEM = 1'b0;
      end
    endcase
    pc_src    = branch_habilitado_MEM & (estado_q == IDLE);
    pc_branch = branch_target_MEM;
  end

  // FSM, memory request registers and MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q            <= IDLE;
      cont_q              <= '0;
      lat_reg_escribir_q  <= 1'b0;
      lat_mem_a_reg_q     <= 1'b0;
      lat_destino_q       <= 5'd0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= 32'd0;
      mem_wdata           <= 32'd0;
      reg_escribir_WB     <= 1'b0;
      mem_a_reg_WB        <= 1'b0;
      dato_leido_WB       <= 32'd0;
      resultado_alu_WB    <= 32'd0;
      registro_destino_WB <= 5'd0;
      error_MEM           <= 1'b0;
    end else begin
      error_MEM <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (hay_op_s) begin
            // Memory instructions leave a bubble in WB until they complete.
            reg_escribir_WB     <= 1'b0;
            mem_a_reg_WB        <= 1'b0;
            dato_leido_WB       <= 32'd0;
            resultado_alu_WB    <= 32'd0;
            registro_destino_WB <= 5'd0;
            if (acceso_valido_s) begin
              mem_req            <= 1'b1;
              mem_we             <= mem_escribir_MEM;
              mem_addr           <= resultado_alu_MEM;
              mem_wdata          <= dr2_forward_MEM;
              lat_reg_escribir_q <= reg_escribir_MEM;
              lat_mem_a_reg_q    <= mem_a_reg_MEM;
              lat_destino_q      <= registro_destino_MEM;
              cont_q             <= '0;
              estado_q           <= ESPERA;
            end else begin
              error_MEM <= 1'b1;
            end
          end else begin
            reg_escribir_WB     <= reg_escribir_MEM & (registro_destino_MEM != 5'd0);
            mem_a_reg_WB        <= mem_a_reg_MEM;
            dato_leido_WB       <= 32'd0;
            resultado_alu_WB    <= resultado_alu_MEM;
            registro_destino_WB <= registro_destino_MEM;
          end
        end
        ESPERA: begin
          if (mem_ack) begin
            // Ack has priority over a simultaneous timeout.
            mem_req             <= 1'b0;
            cont_q              <= '0;
            estado_q            <= IDLE;
            reg_escribir_WB     <= lat_reg_escribir_q & ~mem_we & (lat_destino_q != 5'd0);
            mem_a_reg_WB        <= lat_mem_a_reg_q;
            dato_leido_WB       <= mem_we ? 32'd0 : mem_rdata;
            resultado_alu_WB    <= mem_addr;
            registro_destino_WB <= lat_destino_q;
          end else if (timeout_s) begin
            mem_req             <= 1'b0;
            cont_q              <= '0;
            estado_q            <= IDLE;
            error_MEM           <= 1'b1;
            reg_escribir_WB     <= 1'b0;
            mem_a_reg_WB        <= 1'b0;
            dato_leido_WB       <= 32'd0;
            resultado_alu_WB    <= 32'd0;
            registro_destino_WB <= 5'd0;
          end else begin
            cont_q              <= cont_q + {{(CONT_ANCHO-1){1'b0}}, 1'b1};
            reg_escribir_WB     <= 1'b0;
            mem_a_reg_WB        <= 1'b0;
            dato_leido_WB       <= 32'd0;
            resultado_alu_WB    <= 32'd0;
            registro_destino_WB <= 5'd0;
          end
        end
        default: begin
          estado_q <= IDLE;
          mem_req  <= 1'b0;
          cont_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_mem_wb.sv
module tb_etapa_mem_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_escribir_MEM, mem_a_reg_MEM, mem_escribir_MEM, mem_leer_MEM;
  logic        branch_habilitado_MEM;
  logic [31:0] branch_target_MEM, resultado_alu_MEM, dr2_forward_MEM;
  logic [4:0]  registro_destino_MEM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_MEM, pc_src;
  logic [31:0] pc_branch;
  logic        reg_escribir_WB, mem_a_reg_WB;
  logic [31:0] dato_leido_WB, resultado_alu_WB;
  logic [4:0]  registro_destino_WB;
  logic        error_MEM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  etapa_mem_wb #(.TIMEOUT_CICLOS(4), .CONT_ANCHO(8)) dut (
    .clk(clk), .reset(reset),
    .reg_escribir_MEM(reg_escribir_MEM), .mem_a_reg_MEM(mem_a_reg_MEM),
    .mem_escribir_MEM(mem_escribir_MEM), .mem_leer_MEM(mem_leer_MEM),
    .branch_habilitado_MEM(branch_habilitado_MEM), .branch_target_MEM(branch_target_MEM),
    .resultado_alu_MEM(resultado_alu_MEM), .dr2_forward_MEM(dr2_forward_MEM),
    .registro_destino_MEM(registro_destino_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_MEM(stall_MEM), .pc_src(pc_src), .pc_branch(pc_branch),
    .reg_escribir_WB(reg_escribir_WB), .mem_a_reg_WB(mem_a_reg_WB),
    .dato_leido_WB(dato_leido_WB), .resultado_alu_WB(resultado_alu_WB),
    .registro_destino_WB(registro_destino_WB), .error_MEM(error_MEM)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reg_escribir_MEM = 1'b0; mem_a_reg_MEM = 1'b0; mem_escribir_MEM = 1'b0;
    mem_leer_MEM = 1'b0; branch_habilitado_MEM = 1'b0; branch_target_MEM = 32'd0;
    resultado_alu_MEM = 32'd0; dr2_forward_MEM = 32'd0; registro_destino_MEM = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if ({reg_escribir_WB, mem_a_reg_WB, dato_leido_WB, resultado_alu_WB, registro_destino_WB, error_MEM} !== 71'd0) begin
      errors++; $display("FAIL reset_wb got %b %b %h %h %h %b exp all 0", reg_escribir_WB, mem_a_reg_WB, dato_leido_WB, resultado_alu_WB, registro_destino_WB, error_MEM); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_op();
    reg_escribir_MEM = 1'b1; registro_destino_MEM = 5'd5; resultado_alu_MEM = 32'h0000_002A;
    #1;
    checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_MEM); end
    tick();
    checks++; if (reg_escribir_WB !== 1'b1 || resultado_alu_WB !== 32'h2A || registro_destino_WB !== 5'd5 || dato_leido_WB !== 32'd0) begin
      errors++; $display("FAIL alu_wb got we=%b alu=%h rd=%0d dato=%h exp we=1 alu=2a rd=5 dato=0", reg_escribir_WB, resultado_alu_WB, registro_destino_WB, dato_leido_WB); end
    // Destination x0 must never be written.
    registro_destino_MEM = 5'd0; resultado_alu_MEM = 32'h0000_0077;
    tick();
    checks++; if (reg_escribir_WB !== 1'b0 || resultado_alu_WB !== 32'h77) begin
      errors++; $display("FAIL alu_x0 got we=%b alu=%h exp we=0 alu=77", reg_escribir_WB, resultado_alu_WB); end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_and_idle_ack();
    branch_habilitado_MEM = 1'b1; branch_target_MEM = 32'h0000_1000;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555; resultado_alu_MEM = 32'h0000_0010;
    #1;
    checks++; if (pc_src !== 1'b1 || pc_branch !== 32'h1000) begin
      errors++; $display("FAIL branch_idle got src=%b tgt=%h exp src=1 tgt=1000", pc_src, pc_branch); end
    tick();
    checks++; if (mem_req !== 1'b0 || dato_leido_WB !== 32'd0 || error_MEM !== 1'b0 || resultado_alu_WB !== 32'h10) begin
      errors++; $display("FAIL idle_ack got req=%b dato=%h err=%b alu=%h exp 0 0 0 10", mem_req, dato_leido_WB, error_MEM, resultado_alu_WB); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load();
    mem_leer_MEM = 1'b1; reg_escribir_MEM = 1'b1; mem_a_reg_MEM = 1'b1;
    registro_destino_MEM = 5'd7; resultado_alu_MEM = 32'h0000_0040;
    branch_habilitado_MEM = 1'b1; branch_target_MEM = 32'h0000_2000;
    #1;
    checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL load_detect_stall got %b exp 1", stall_MEM); end
    tick(); // ESPERA 1
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++; $display("FAIL load_req got req=%b addr=%h we=%b exp 1 40 0", mem_req, mem_addr, mem_we); end
    checks++; if (stall_MEM !== 1'b1 || reg_escribir_WB !== 1'b0 || pc_src !== 1'b0) begin
      errors++; $display("FAIL load_wait1 got stall=%b wbwe=%b pcsrc=%b exp 1 0 0", stall_MEM, reg_escribir_WB, pc_src); end
    tick(); // ESPERA 2
    checks++; if (stall_MEM !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL load_wait2 got stall=%b req=%b addr=%h exp 1 1 40", stall_MEM, mem_req, mem_addr); end
    tick(); // ESPERA 3, ack here
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL load_ack_stall got %b exp 0", stall_MEM); end
    tick();
    clear_inputs();
    checks++; if (mem_req !== 1'b0 || dato_leido_WB !== 32'hDEAD_BEEF || mem_a_reg_WB !== 1'b1) begin
      errors++; $display("FAIL load_done got req=%b dato=%h m2r=%b exp 0 deadbeef 1", mem_req, dato_leido_WB, mem_a_reg_WB); end
    checks++; if (reg_escribir_WB !== 1'b1 || registro_destino_WB !== 5'd7 || resultado_alu_WB !== 32'h40 || error_MEM !== 1'b0) begin
      errors++; $display("FAIL load_wb got we=%b rd=%0d alu=%h err=%b exp 1 7 40 0", reg_escribir_WB, registro_destino_WB, resultado_alu_WB, error_MEM); end
    tick();
  endtask

  task automatic test_store();
    mem_escribir_MEM = 1'b1; reg_escribir_MEM = 1'b1; registro_destino_MEM = 5'd3;
    resultado_alu_MEM = 32'h0000_0080; dr2_forward_MEM = 32'h1234_5678;
    #1;
    checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL store_detect_stall got %b exp 1", stall_MEM); end
    tick(); // ESPERA 1 with ack
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h80) begin
      errors++; $display("FAIL store_req got req=%b we=%b wdata=%h addr=%h exp 1 1 12345678 80", mem_req, mem_we, mem_wdata, mem_addr); end
    checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL store_ack_stall got %b exp 0", stall_MEM); end
    tick();
    clear_inputs();
    checks++; if (mem_req !== 1'b0 || reg_escribir_WB !== 1'b0 || dato_leido_WB !== 32'd0 || error_MEM !== 1'b0) begin
      errors++; $display("FAIL store_done got req=%b wbwe=%b dato=%h err=%b exp 0 0 0 0", mem_req, reg_escribir_WB, dato_leido_WB, error_MEM); end
    tick();
  endtask

  task automatic test_invalid();
    for (int v = 0; v < 2; v++) begin
      // v=0: misaligned load; v=1: aligned read+write conflict
      reg_escribir_MEM = 1'b1; registro_destino_MEM = 5'd4; mem_leer_MEM = 1'b1;
      mem_escribir_MEM = (v == 1);
      resultado_alu_MEM = (v == 0) ? 32'h0000_0042 : 32'h0000_0040;
      #1;
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL invalid%0d_stall got %b exp 0", v, stall_MEM); end
      tick();
      clear_inputs();
      checks++; if (mem_req !== 1'b0 || error_MEM !== 1'b1 || reg_escribir_WB !== 1'b0) begin
        errors++; $display("FAIL invalid%0d_resp got req=%b err=%b wbwe=%b exp 0 1 0", v, mem_req, error_MEM, reg_escribir_WB); end
      tick();
      checks++; if (error_MEM !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL invalid%0d_pulse got err=%b req=%b exp 0 0", v, error_MEM, mem_req); end
    end
  endtask

  task automatic test_timeout();
    for (int r = 0; r < 2; r++) begin
      // r=0: no ack; r=1: ack arrives in the 4th (timeout) ESPERA cycle
      mem_leer_MEM = 1'b1; reg_escribir_MEM = 1'b1; registro_destino_MEM = 5'd9;
      resultado_alu_MEM = 32'h0000_0020;
      tick();
      for (int k = 1; k <= 4; k++) begin
        if (r == 1 && k == 4) begin
          mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        end
        #1;
        checks++; if (mem_req !== 1'b1 || stall_MEM !== (k < 4)) begin
          errors++; $display("FAIL timeout%0d_wait%0d got req=%b stall=%b exp 1 %b", r, k, mem_req, stall_MEM, (k < 4)); end
        tick();
      end
      clear_inputs();
      if (r == 0) begin
        checks++; if (mem_req !== 1'b0 || error_MEM !== 1'b1 || reg_escribir_WB !== 1'b0) begin
          errors++; $display("FAIL timeout_abort got req=%b err=%b wbwe=%b exp 0 1 0", mem_req, error_MEM, reg_escribir_WB); end
      end else begin
        checks++; if (mem_req !== 1'b0 || error_MEM !== 1'b0 || reg_escribir_WB !== 1'b1 || dato_leido_WB !== 32'hCAFE_F00D) begin
          errors++; $display("FAIL timeout_ackwins got req=%b err=%b wbwe=%b dato=%h exp 0 0 1 cafef00d", mem_req, error_MEM, reg_escribir_WB, dato_leido_WB); end
      end
      tick();
      checks++; if (error_MEM !== 1'b0) begin errors++; $display("FAIL timeout%0d_pulse got %b exp 0", r, error_MEM); end
    end
  endtask

  task automatic test_reset_mid_access();
    mem_leer_MEM = 1'b1; reg_escribir_MEM = 1'b1; registro_destino_MEM = 5'd2;
    resultado_alu_MEM = 32'h0000_0100;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL rstmid_req got req=%b addr=%h exp 1 100", mem_req, mem_addr); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || reg_escribir_WB !== 1'b0 || dato_leido_WB !== 32'd0 || registro_destino_WB !== 5'd0) begin
      errors++; $display("FAIL rstmid_async got req=%b addr=%h wbwe=%b dato=%h rd=%0d exp all 0", mem_req, mem_addr, reg_escribir_WB, dato_leido_WB, registro_destino_WB); end
    clear_inputs();
    tick();
    reset = 1'b1;
    branch_habilitado_MEM = 1'b1; branch_target_MEM = 32'h0000_0300;
    #1;
    checks++; if (pc_src !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got pcsrc=%b req=%b exp 1 0", pc_src, mem_req); end
    tick();
    checks++; if (reg_escribir_WB !== 1'b0 || error_MEM !== 1'b0) begin
      errors++; $display("FAIL rstmid_nowb got wbwe=%b err=%b exp 0 0", reg_escribir_WB, error_MEM); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_branch_and_idle_ack();
    test_load();
    test_store();
    test_invalid();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etapa_mem_wb.md
Name: etapa_mem_wb

Overview:
- MEM-stage controller: consumes the EX/MEM pipeline buffer outputs, performs load/store on the data memory through a req/ack handshake, and drives the MEM/WB pipeline register.
- Also resolves the branch redirect to the PC and raises a stall to the hazard unit while a memory access is outstanding.
- Sits between the EX/MEM buffer and the register-file write-back mux.

Parameters:
TIMEOUT_CICLOS, 255, ESPERA cycles without mem_ack before the access is aborted
CONT_ANCHO, 8, width of the timeout counter; must hold TIMEOUT_CICLOS

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
reg_escribir_MEM  input  1  register write enable from EX/MEM
mem_a_reg_MEM  input  1  write-back source select (1 = memory data)
mem_escribir_MEM  input  1  store request
mem_leer_MEM  input  1  load request
branch_habilitado_MEM  input  1  branch taken
branch_target_MEM  input  32  branch target address
resultado_alu_MEM  input  32  ALU result / memory address
dr2_forward_MEM  input  32  store data
registro_destino_MEM  input  5  destination register
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write, 0 = read, registered
mem_addr  output  32  registered word address
mem_wdata  output  32  registered store data
mem_ack  input  1  memory completion, one-cycle pulse
mem_rdata  input  32  read data, valid when mem_ack = 1
stall_MEM  output  1  freeze upstream stages, combinational
pc_src  output  1  PC redirect select, combinational
pc_branch  output  32  PC redirect target, combinational
reg_escribir_WB  output  1  MEM/WB register write enable
mem_a_reg_WB  output  1  MEM/WB source select
dato_leido_WB  output  32  MEM/WB load data
resultado_alu_WB  output  32  MEM/WB ALU result
registro_destino_WB  output  5  MEM/WB destination register
error_MEM  output  1  one-cycle pulse: misalignment, read+write conflict, or timeout

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, counter 0, every registered output 0. mem_req drops immediately, including mid-access. No WB write is produced for the aborted instruction.
- States: IDLE, ESPERA.
- IDLE, no memory op (mem_leer_MEM = mem_escribir_MEM = 0):
  - WB registers load on the next edge: reg_escribir, mem_a_reg, ALU result, destination; dato_leido_WB = 0.
  - Latency 1 cycle. stall_MEM = 0.
- IDLE, valid access (exactly one of read/write, resultado_alu_MEM[1:0] = 00):
  - stall_MEM = 1 in the same cycle.
  - Latch addr, wdata, we (= mem_escribir_MEM), reg_escribir, mem_a_reg, destination.
  - mem_req <= 1. WB receives a bubble (reg_escribir_WB = 0). Go to ESPERA.
- IDLE, invalid access (misaligned, or read and write both 1):
  - No request. WB bubble. error_MEM = 1 on the next cycle. stall_MEM = 0. Stay in IDLE.
- ESPERA:
  - mem_req = 1 and mem_addr / mem_wdata / mem_we held stable; stall_MEM = ~mem_ack.
  - On mem_ack = 1, at that edge:
    - mem_req <= 0; state <= IDLE; counter cleared.
    - WB loads the latched fields. dato_leido_WB = mem_rdata for a load, 0 for a store.
    - Stores force reg_escribir_WB = 0.
  - Minimum access latency: 2 cycles (detect + ack cycle).
- Timeout: counter increments each ESPERA cycle without ack. When it reaches TIMEOUT_CICLOS:
  - stall_MEM = 0 in that cycle.
  - Next edge: mem_req <= 0, state IDLE, WB bubble, error_MEM pulse.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- mem_ack while in IDLE: ignored.
- Register 0: reg_escribir_WB is forced to 0 whenever the destination is 5'd0.
- Branch:
  - pc_src = branch_habilitado_MEM & (state == IDLE); pc_branch = branch_target_MEM.
  - A branch carries no memory op; it passes to WB as a normal non-memory instruction.
- error_MEM is never asserted for two consecutive cycles from a single instruction.

Test Plan:
- Reset mid-ESPERA: load to 0x100, drop reset while mem_req = 1 -> mem_req = 0 immediately, all WB outputs 0, state IDLE after release.
- ALU op: resultado_alu_MEM = 0x0000_002A, dest 5, reg_escribir = 1 -> next cycle reg_escribir_WB = 1, resultado_alu_WB = 0x2A, registro_destino_WB = 5, stall_MEM never 1.
- Load from 0x0000_0040, ack after 3 ESPERA cycles with mem_rdata = 0xDEADBEEF:
  - stall_MEM high from the detect cycle through the cycle before ack.
  - mem_addr = 0x40, mem_we = 0.
  - After the ack edge: dato_leido_WB = 0xDEADBEEF, mem_a_reg_WB = 1.
- Store of 0x12345678 to 0x0000_0080, ack on the first ESPERA cycle -> mem_we = 1, mem_wdata = 0x12345678, reg_escribir_WB = 0, total stall 2 cycles.
- Misaligned load to 0x0000_0042 -> mem_req stays 0, error_MEM pulses once, WB bubble. Same response for read + write both set.
- Timeout with TIMEOUT_CICLOS = 4 and no ack -> mem_req drops after 4 ESPERA cycles, error_MEM pulses, WB bubble. Repeat with ack on cycle 4 -> normal completion, no error.
